// File: rtl/pacman_mover.sv
// Pac-Man grid position controller: buffers a turn request, checks the target
// cell through one combinational maze-ROM row read and commits or refuses each step.
module pacman_mover #(
  parameter int DATA_WIDTH = 22,
  parameter int ADDR_WIDTH = 5,
  parameter int ROWS       = 19,
  parameter int START_ROW  = 17,
  parameter int START_COL  = 10,
  parameter int START_DIR  = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          move_tick,
  input  logic                          dir_valid,
  input  logic [1:0]                    dir_req,
  output logic [ADDR_WIDTH-1:0]         row_addr,
  input  logic [DATA_WIDTH-1:0]         row_data,
  output logic [ADDR_WIDTH-1:0]         pos_row,
  output logic [$clog2(DATA_WIDTH)-1:0] pos_col,
  output logic [1:0]                    cur_dir,
  output logic                          moved,
  output logic                          blocked,
  output logic                          tick_dropped
);

  localparam int COL_W = $clog2(DATA_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ROW_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ROW_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(ROWS - 1);
  localparam logic [COL_W-1:0]      COL_ZERO = {COL_W{1'b0}};
  localparam logic [COL_W-1:0]      COL_ONE  = COL_W'(1);
  localparam logic [COL_W-1:0]      LAST_COL = COL_W'(DATA_WIDTH - 1);

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CHK_REQ = 2'd1,
    CHK_CUR = 2'd2
  } state_t;

  state_t               state_r;
  logic                 pend_valid_r;
  logic [1:0]           pend_dir_r;

  logic [1:0]           chk_dir_s;
  logic [ADDR_WIDTH-1:0] tgt_row_s;
  logic [COL_W-1:0]     tgt_col_s;
  logic                 edge_blk_s;
  logic                 open_s;

  // The ROM row stores column 0 in its MSB; a 0 bit is an open cell.
  function automatic logic cell_open(input logic [DATA_WIDTH-1:0] row,
                                     input logic [COL_W-1:0]      col);
    logic [COL_W-1:0] idx;
    idx = LAST_COL - col;
    return ~row[idx];
  endfunction

  assign chk_dir_s = (state_r == CHK_REQ) ? pend_dir_r : cur_dir;

  // Target cell of the direction under test, with tunnel wrap and top/bottom edge block.
  always_comb begin
    tgt_row_s  = pos_row;
    tgt_col_s  = pos_col;
    edge_blk_s = 1'b0;
    case (chk_dir_s)
      DIR_UP: begin
        if (pos_row == ROW_ZERO) begin
          edge_blk_s = 1'b1;
        end else begin
          tgt_row_s = pos_row - ROW_ONE;
        end
      end
      DIR_RIGHT: begin
        if (pos_col == LAST_COL) begin
          tgt_col_s = COL_ZERO;
        end else begin
          tgt_col_s = pos_col + COL_ONE;
        end
      end
      DIR_DOWN: begin
        if (pos_row == LAST_ROW) begin
          edge_blk_s = 1'b1;
        end else begin
          tgt_row_s = pos_row + ROW_ONE;
        end
      end
      DIR_LEFT: begin
        if (pos_col == COL_ZERO) begin
          tgt_col_s = LAST_COL;
        end else begin
          tgt_col_s = pos_col - COL_ONE;
        end
      end
      default: begin
        edge_blk_s = 1'b1;
      end
    endcase
  end

  // ROM address: current row while idle, otherwise the row holding the target cell.
  always_comb begin
    if (state_r == IDLE) begin
      row_addr = pos_row;
    end else begin
      row_addr = tgt_row_s;
    end
  end

  assign open_s = ~edge_blk_s & cell_open(row_data, tgt_col_s);

  // Movement FSM with position, direction, pending request and status pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      pos_row      <= ADDR_WIDTH'(START_ROW);
      pos_col      <= COL_W'(START_COL);
      cur_dir      <= 2'(START_DIR);
      pend_valid_r <= 1'b0;
      pend_dir_r   <= 2'd0;
      moved        <= 1'b0;
      blocked      <= 1'b0;
      tick_dropped <= 1'b0;
    end else begin
      moved        <= 1'b0;
      tick_dropped <= move_tick & (state_r != IDLE);

      // A fresh request always wins over the one a commit is consuming.
      if (dir_valid) begin
        pend_valid_r <= 1'b1;
        pend_dir_r   <= dir_req;
      end else if ((state_r == CHK_REQ) && open_s) begin
        pend_valid_r <= 1'b0;
      end else begin
        pend_valid_r <= pend_valid_r;
      end

      case (state_r)
        IDLE: begin
          if (move_tick) begin
            state_r <= pend_valid_r ? CHK_REQ : CHK_CUR;
          end else begin
            state_r <= IDLE;
          end
        end
        CHK_REQ: begin
          if (open_s) begin
            pos_row <= tgt_row_s;
            pos_col <= tgt_col_s;
            cur_dir <= pend_dir_r;
            moved   <= 1'b1;
            blocked <= 1'b0;
            state_r <= IDLE;
          end else begin
            state_r <= CHK_CUR;
          end
        end
        CHK_CUR: begin
          if (open_s) begin
            pos_row <= tgt_row_s;
            pos_col <= tgt_col_s;
            moved   <= 1'b1;
            blocked <= 1'b0;
          end else begin
            blocked <= 1'b1;
          end
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  pacman_mover_checker #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .COL_W      (COL_W),
    .ROWS       (ROWS),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_checker (
    .clk     (clk),
    .reset   (reset),
    .state   (state_r),
    .pos_row (pos_row),
    .pos_col (pos_col),
    .moved   (moved),
    .blocked (blocked)
  );

endmodule

// Invariants of the mover: legal state, position inside the maze, commit clears blocked.
module pacman_mover_checker #(
  parameter int ADDR_WIDTH = 5,
  parameter int COL_W      = 5,
  parameter int ROWS       = 19,
  parameter int DATA_WIDTH = 22
) (
  input logic                  clk,
  input logic                  reset,
  input logic [1:0]            state,
  input logic [ADDR_WIDTH-1:0] pos_row,
  input logic [COL_W-1:0]      pos_col,
  input logic                  moved,
  input logic                  blocked
);

  a_state_legal: assert property (@(posedge clk) disable iff (reset) state != 2'd3);
  a_row_range:   assert property (@(posedge clk) disable iff (reset) int'(pos_row) < ROWS);
  a_col_range:   assert property (@(posedge clk) disable iff (reset) int'(pos_col) < DATA_WIDTH);
  a_move_clear:  assert property (@(posedge clk) disable iff (reset) moved |-> !blocked);

endmodule

// File: tb/tb_pacman_mover.sv
// Vector/scoreboard bench for pacman_mover: a default-parameter unit in a small
// maze plus a tunnel-row unit, sharing one behavioural maze ROM.
module tb_pacman_mover;

  logic clk;
  logic reset;

  logic       tick0, dv0, tick1, dv1;
  logic [1:0] dr0, dr1;
  logic [4:0] raddr0, raddr1, prow0, prow1, pcol0, pcol1;
  logic [21:0] rdata0, rdata1;
  logic [1:0] cdir0, cdir1;
  logic       mv0, mv1, bl0, bl1, dp0, dp1;

  logic [21:0] rom [0:31];

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit         sel;
    bit         tick;
    bit         dv;
    logic [1:0] dr;
    logic [4:0] row;
    logic [4:0] col;
    logic [1:0] dir;
    logic       mv;
    logic       bl;
    logic       dp;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  pacman_mover u_main (
    .clk(clk), .reset(reset), .move_tick(tick0), .dir_valid(dv0), .dir_req(dr0),
    .row_addr(raddr0), .row_data(rdata0), .pos_row(prow0), .pos_col(pcol0),
    .cur_dir(cdir0), .moved(mv0), .blocked(bl0), .tick_dropped(dp0)
  );

  pacman_mover #(.START_ROW(9), .START_COL(0), .START_DIR(3)) u_tun (
    .clk(clk), .reset(reset), .move_tick(tick1), .dir_valid(dv1), .dir_req(dr1),
    .row_addr(raddr1), .row_data(rdata1), .pos_row(prow1), .pos_col(pcol1),
    .cur_dir(cdir1), .moved(mv1), .blocked(bl1), .tick_dropped(dp1)
  );

  assign rdata0 = rom[raddr0];
  assign rdata1 = rom[raddr1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(bit sel, bit tick, bit dv, int dr, int row, int col,
                              int dir, bit mv, bit bl, bit dp);
    vec_t v;
    v.sel = sel; v.tick = tick; v.dv = dv; v.dr = 2'(dr);
    v.row = 5'(row); v.col = 5'(col); v.dir = 2'(dir);
    v.mv = mv; v.bl = bl; v.dp = dp;
    return v;
  endfunction

  task automatic cmp(string name, logic [4:0] act, logic [4:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic check(vec_t e);
    if (e.sel) begin
      cmp("tun.pos_row", prow1, e.row);
      cmp("tun.pos_col", pcol1, e.col);
      cmp("tun.cur_dir", {3'd0, cdir1}, {3'd0, e.dir});
      cmp("tun.moved", {4'd0, mv1}, {4'd0, e.mv});
      cmp("tun.blocked", {4'd0, bl1}, {4'd0, e.bl});
      cmp("tun.tick_dropped", {4'd0, dp1}, {4'd0, e.dp});
    end else begin
      cmp("main.pos_row", prow0, e.row);
      cmp("main.pos_col", pcol0, e.col);
      cmp("main.cur_dir", {3'd0, cdir0}, {3'd0, e.dir});
      cmp("main.moved", {4'd0, mv0}, {4'd0, e.mv});
      cmp("main.blocked", {4'd0, bl0}, {4'd0, e.bl});
      cmp("main.tick_dropped", {4'd0, dp0}, {4'd0, e.dp});
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic run(vec_t v);
    vec_t e;
    tick0 = 1'b0; dv0 = 1'b0; dr0 = 2'd0;
    tick1 = 1'b0; dv1 = 1'b0; dr1 = 2'd0;
    if (v.sel) begin
      tick1 = v.tick; dv1 = v.dv; dr1 = v.dr;
    end else begin
      tick0 = v.tick; dv0 = v.dv; dr0 = v.dr;
    end
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check(e);
  endtask

  task automatic idle_inputs();
    tick0 = 1'b0; dv0 = 1'b0; dr0 = 2'd0;
    tick1 = 1'b0; dv1 = 1'b0; dr1 = 2'd0;
  endtask

  initial begin
    // Maze: all wall except row 17 cols 1..20, row 16 col 7, and the full tunnel row 9.
    for (int r = 0; r < 32; r++) rom[r] = {22{1'b1}};
    for (int c = 1; c <= 20; c++) rom[17][21-c] = 1'b0;
    rom[16][21-7] = 1'b0;
    rom[9] = 22'd0;

    // sel tick dv dr   row col dir mv bl dp
    vecs.push_back(mk(0,1,0,0, 17,10,3, 0,0,0));
    vecs.push_back(mk(0,0,0,0, 17, 9,3, 1,0,0));
    vecs.push_back(mk(0,0,0,0, 17, 9,3, 0,0,0));
    vecs.push_back(mk(0,0,1,0, 17, 9,3, 0,0,0));
    vecs.push_back(mk(0,1,0,0, 17, 9,3, 0,0,0));
    vecs.push_back(mk(0,0,0,0, 17, 9,3, 0,0,0));
    vecs.push_back(mk(0,0,0,0, 17, 8,3, 1,0,0));
    vecs.push_back(mk(0,0,0,0, 17, 8,3, 0,0,0));
    vecs.push_back(mk(0,1,0,0, 17, 8,3, 0,0,0));
    vecs.push_back(mk(0,0,0,0, 17, 8,3, 0,0,0));
    vecs.push_back(mk(0,0,0,0, 17, 7,3, 1,0,0));
    vecs.push_back(mk(0,0,0,0, 17, 7,3, 0,0,0));
    vecs.push_back(mk(0,1,0,0, 17, 7,3, 0,0,0));
    vecs.push_back(mk(0,0,0,0, 16, 7,0, 1,0,0));
    vecs.push_back(mk(0,0,0,0, 16, 7,0, 0,0,0));
    vecs.push_back(mk(0,1,0,0, 16, 7,0, 0,0,0));
    vecs.push_back(mk(0,0,0,0, 16, 7,0, 0,1,0));
    vecs.push_back(mk(0,1,0,0, 16, 7,0, 0,1,0));
    vecs.push_back(mk(0,1,0,0, 16, 7,0, 0,1,1));
    vecs.push_back(mk(0,0,0,0, 16, 7,0, 0,1,0));
    vecs.push_back(mk(0,0,1,2, 16, 7,0, 0,1,0));
    vecs.push_back(mk(0,1,0,0, 16, 7,0, 0,1,0));
    vecs.push_back(mk(0,0,1,1, 17, 7,2, 1,0,0));
    vecs.push_back(mk(0,1,0,0, 17, 7,2, 0,0,0));
    vecs.push_back(mk(0,0,0,0, 17, 8,1, 1,0,0));
    vecs.push_back(mk(0,0,0,0, 17, 8,1, 0,0,0));
    vecs.push_back(mk(1,1,0,0,  9, 0,3, 0,0,0));
    vecs.push_back(mk(1,0,0,0,  9,21,3, 1,0,0));
    vecs.push_back(mk(1,0,1,1,  9,21,3, 0,0,0));
    vecs.push_back(mk(1,1,0,0,  9,21,3, 0,0,0));
    vecs.push_back(mk(1,0,0,0,  9, 0,1, 1,0,0));
    vecs.push_back(mk(1,0,0,0,  9, 0,1, 0,0,0));

    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check(mk(0,0,0,0, 17,10,3, 0,0,0));
    check(mk(1,0,0,0,  9, 0,3, 0,0,0));

    foreach (vecs[i]) run(vecs[i]);

    // Walk left from the start cell into the column-0 wall, then turn right.
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 9; i++) begin
      run(mk(0,1,0,0, 17,10-i,  3, 0,0,0));
      run(mk(0,0,0,0, 17,10-i-1,3, 1,0,0));
      run(mk(0,0,0,0, 17,10-i-1,3, 0,0,0));
    end
    run(mk(0,1,0,0, 17,1,3, 0,0,0));
    run(mk(0,0,0,0, 17,1,3, 0,1,0));
    run(mk(0,0,1,1, 17,1,3, 0,1,0));
    run(mk(0,1,0,0, 17,1,3, 0,1,0));
    run(mk(0,0,0,0, 17,2,1, 1,0,0));

    // Reset asserted mid-cycle while the check of cur_dir is in flight.
    run(mk(0,1,0,0, 17,2,1, 0,0,0));
    idle_inputs();
    #2;
    reset = 1'b1;
    #1;
    check(mk(0,0,0,0, 17,10,3, 0,0,0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    check(mk(0,0,0,0, 17,10,3, 0,0,0));
    run(mk(0,0,0,0, 17,10,3, 0,0,0));
    run(mk(0,0,0,0, 17,10,3, 0,0,0));

    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
